light_sequencer: RTL and testbench
==================================

// Module: light_sequencer
// PURPOSE
//  Controller that drives the lights selector datapath: chooses the 3-bit colour code and presents the 24-bit light word.
//  Two stepping modes: manual, advancing once per debounced button press; auto, advancing every DWELL cycles.
//  Sits between the raw push-button/mode switches and the RGB light output. Owns input synchronising, debouncing, timing and sequencing.
// PARAMETERS
//  DEBOUNCE  16'd50000  consecutive synced cycles button must hold a level to count as pressed/released (>=1)
//  DWELL     32'd5000000  cycles each colour is held in auto mode (>=2)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  button     in   1   raw asynchronous push-button, 1 = pressed
//  enable     in   1   1 = sequencer running, 0 = lights off
//  auto_mode  in   1   1 = timed stepping, 0 = button stepping
//  sel        in   1   1 = show colour, 0 = force white
//  colour     out  3   current colour code {R,G,B}
//  light      out  24  {8{colour[2]},8{colour[1]},8{colour[0]}} when sel=1; 24'hFFFFFF when sel=0
//  step       out  1   one-cycle pulse on the cycle colour changes between two non-zero codes
// BEHAVIOUR
//  Reset (rst=0, async): state=OFF, colour=3'b000, step=0, timer=0, debounce counter=0, press armed.
//    light then = sel ? 24'h000000 : 24'hFFFFFF.
//  light: combinational decode of registered colour and sel. Zero added latency relative to colour.
//  Button path:
//    - 2-flop synchroniser, then debounce counter on the synced level.
//    - Press event (1 cycle) fires when synced=1 for DEBOUNCE consecutive cycles while armed; this disarms.
//    - Re-arm needs synced=0 for DEBOUNCE consecutive cycles. Any level change before the count completes restarts the counter.
//    - Held button = exactly one press. Glitches shorter than DEBOUNCE cycles are ignored.
//    - Latency: colour updates on clk edge DEBOUNCE+3, counting the edge that first samples button=1 as edge 1.
//  FSM states: OFF, MANUAL, AUTO.
//    OFF    : colour=000, timer=0. enable=1 -> colour<=001, state<=auto_mode?AUTO:MANUAL (next edge). step not pulsed.
//    MANUAL : press event -> advance colour, step=1. auto_mode=1 -> AUTO, timer<=0, colour kept.
//    AUTO   : timer counts 0..DWELL-1; at DWELL-1 -> advance, timer<=0, step=1.
//             press event -> advance, timer<=0, step=1. Press and timer expiry on the same cycle = single advance.
//             auto_mode=0 -> MANUAL, timer<=0, colour kept.
//    Any state: enable=0 -> OFF next edge, colour<=000, timer<=0. This has priority over press/expiry.
//  Advance sequence: 001,010,011,100,101,110,111, then wrap to 001. 000 is never produced while enabled.
//  Timer width = $clog2(DWELL). No overflow; cleared on every advance or mode change.
//  Press events are still detected in OFF but discarded (no queued steps).
//  Mid-operation reset clears all state at once. After release, the first edge with enable=1 gives colour 001.
//  sel affects light only; colour, timer and FSM are independent of sel.
// TESTING (bench: DEBOUNCE=4, DWELL=8, clk period 10ns)
//  1. rst=0 with sel=1 then sel=0 -> colour=000, light=000000 then FFFFFF, step=0. Release rst, enable=0 -> unchanged.
//  2. enable=1, auto_mode=0 -> colour=001 next edge. Hold button 20 cycles -> exactly one step, colour=010, at edge 7.
//  3. 3-cycle button glitch -> no step. Release 4 cycles, press again -> colour=011.
//  4. auto_mode=1 from 111 -> 001 after 8 cycles, then 010 after 8 more. step pulses exactly once per change.
//  5. In AUTO, press timed so the event hits timer=7 -> single advance, timer restarts at 0.
//  6. enable=0 mid-AUTO -> colour=000 next edge. sel=0 at any time -> light=FFFFFF while colour keeps sequencing.

Source files
------------

// File: rtl/light_sequencer.sv
// light_sequencer
// Steps a 3-bit {R,G,B} colour code through 001..111 and presents it as a
// 24-bit light word. Stepping is either manual (one step per debounced
// button press) or automatic (one step every DWELL cycles). The block owns
// button synchronising, debouncing, the dwell timer and the mode FSM.
// Reset is asynchronous and active-low on the rst port.

module light_sequencer #(
    parameter logic [15:0] DEBOUNCE = 16'd50000,   // stable synced cycles per press/release (>=1)
    parameter logic [31:0] DWELL    = 32'd5000000  // cycles each colour is held in auto mode (>=2)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    input  logic        enable,
    input  logic        auto_mode,
    input  logic        sel,
    output logic [2:0]  colour,
    output logic [23:0] light,
    output logic        step
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int unsigned     TW         = $clog2(DWELL);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(DWELL - 32'd1);
    localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
    localparam logic [15:0]     DEB_LAST   = DEBOUNCE - 16'd1;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_MANUAL = 2'd1,
        S_AUTO   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button synchroniser
    // ------------------------------------------------------------------
    logic btn_meta;
    logic btn_sync;

    // Two-flop synchroniser for the raw asynchronous button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here make both flops sample the
            // pre-edge values, giving a true two-stage shift instead of one.
            btn_meta <= button;
            btn_sync <= btn_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------
    // While armed the debouncer waits for DEBOUNCE consecutive synced 1s and
    // then emits one press; while disarmed it waits for DEBOUNCE consecutive
    // synced 0s and then re-arms. The level being waited for is therefore
    // the armed flag itself, and any deviation from it restarts the count.
    logic        armed;
    logic [15:0] deb_cnt;
    logic        deb_match;
    logic        deb_done;
    logic        press;

    assign deb_match = (btn_sync == armed);
    assign deb_done  = deb_match && (deb_cnt == DEB_LAST);

    // Debounce counter, arm/disarm flag and the registered press pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed   <= 1'b1;
            deb_cnt <= 16'd0;
            press   <= 1'b0;
        end else begin
            // The press is registered once so the colour moves on edge
            // DEBOUNCE+3 after the button is first sampled high.
            press <= deb_done && armed;
            if (!deb_match) begin
                deb_cnt <= 16'd0;
            end else if (deb_done) begin
                deb_cnt <= 16'd0;
                armed   <= ~armed;
            end else begin
                deb_cnt <= deb_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t          state_q;
    state_t          state_d;
    logic [2:0]      colour_q;
    logic [2:0]      colour_d;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;
    logic            step_q;
    logic            step_d;
    logic [2:0]      colour_next;
    logic            timer_expired;

    // Advance order is 001..111 then back to 001; 000 is reserved for off.
    assign colour_next   = (colour_q == 3'b111) ? 3'b001 : colour_q + 3'd1;
    assign timer_expired = (timer_q == TIMER_LAST);

    // State, colour, dwell timer and step pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_OFF;
            colour_q <= 3'b000;
            timer_q  <= '0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            colour_q <= colour_d;
            timer_q  <= timer_d;
            step_q   <= step_d;
        end
    end

    // Next-state logic: enable dominates, then mode changes, then advances.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path can leave a signal unassigned and infer a latch.
        state_d  = state_q;
        colour_d = colour_q;
        timer_d  = timer_q;
        step_d   = 1'b0;

        if (!enable) begin
            // Switching off wins over any pending press or timer expiry.
            state_d  = S_OFF;
            colour_d = 3'b000;
            timer_d  = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    // Power-up colour is 001 and is not reported as a step.
                    state_d  = auto_mode ? S_AUTO : S_MANUAL;
                    colour_d = 3'b001;
                    timer_d  = '0;
                end

                S_MANUAL: begin
                    if (auto_mode) begin
                        // Mode change keeps the colour and starts a fresh dwell.
                        state_d = S_AUTO;
                        timer_d = '0;
                    end else if (press) begin
                        colour_d = colour_next;
                        step_d   = 1'b1;
                    end
                end

                S_AUTO: begin
                    if (!auto_mode) begin
                        state_d = S_MANUAL;
                        timer_d = '0;
                    end else if (press || timer_expired) begin
                        // A press landing on expiry still yields one advance.
                        colour_d = colour_next;
                        timer_d  = '0;
                        step_d   = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end

                default: begin
                    state_d  = S_OFF;
                    colour_d = 3'b000;
                    timer_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign colour = colour_q;
    assign step   = step_q;

    // Each colour bit fans out to a full 8-bit channel; sel=0 forces white.
    assign light = sel ? {{8{colour_q[2]}}, {8{colour_q[1]}}, {8{colour_q[0]}}}
                       : 24'hFF_FFFF;

endmodule

// File: tb/tb_light_sequencer.sv
// tb_light_sequencer
// Directed walk through the main behaviours followed by a randomised soak.
// Every cycle the DUT outputs are compared with a behavioural model that
// works from button sample history, streak lengths and cycle timestamps.

module tb_light_sequencer;

    localparam int DEB = 4;
    localparam int DW  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        button;
    logic        enable;
    logic        auto_mode;
    logic        sel;
    logic [2:0]  colour;
    logic [23:0] light;
    logic        step;

    int n_cmp  = 0;
    int n_fail = 0;

    light_sequencer #(
        .DEBOUNCE (16'd4),
        .DWELL    (32'd8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .enable    (enable),
        .auto_mode (auto_mode),
        .sel       (sel),
        .colour    (colour),
        .light     (light),
        .step      (step)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int m_mode;     // 0 = off, 1 = manual, 2 = auto
    int m_col;      // colour as an integer 0..7
    bit m_step;
    bit m_s1;       // button one edge ago
    bit m_sync;     // button two edges ago
    int run1;       // consecutive synced 1 samples
    int run0;       // consecutive synced 0 samples
    bit m_armed;
    bit m_press;    // press recognised on the previous edge
    int cyc;        // edge counter
    int t0;         // edge at which the current auto dwell started

    function automatic logic [23:0] exp_light(input int c, input logic s);
        logic [23:0] w;
        w = 24'h000000;
        if (!s)
            w = 24'hFFFFFF;
        else begin
            if (c[2]) w[23:16] = 8'hFF;
            if (c[1]) w[15:8]  = 8'hFF;
            if (c[0]) w[7:0]   = 8'hFF;
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_col   = 0;
        m_step  = 0;
        m_s1    = 0;
        m_sync  = 0;
        run1    = 0;
        run0    = 0;
        m_armed = 1;
        m_press = 0;
        t0      = cyc;
    endtask

    // One rising edge of model time, using the inputs present before it.
    task automatic model_edge();
        bit new_press;
        m_step = 0;
        if (!enable) begin
            m_mode = 0;
            m_col  = 0;
        end else if (m_mode == 0) begin
            m_col  = 1;
            m_mode = auto_mode ? 2 : 1;
            t0     = cyc;
        end else if (m_mode == 1) begin
            if (auto_mode) begin
                m_mode = 2;
                t0     = cyc;
            end else if (m_press) begin
                m_col  = m_col % 7 + 1;
                m_step = 1;
            end
        end else begin
            if (!auto_mode) begin
                m_mode = 1;
            end else if (m_press || (cyc - t0 == DW)) begin
                m_col  = m_col % 7 + 1;
                m_step = 1;
                t0     = cyc;
            end
        end

        new_press = 0;
        if (m_sync) begin
            run1++;
            run0 = 0;
        end else begin
            run0++;
            run1 = 0;
        end
        if (m_armed && run1 == DEB) begin
            new_press = 1;
            m_armed   = 0;
        end else if (!m_armed && run0 == DEB) begin
            m_armed = 1;
        end
        m_press = new_press;
        m_sync  = m_s1;
        m_s1    = button;
    endtask

    task automatic compare_all();
        check("colour", {21'd0, colour}, 24'(m_col));
        check("light",  light, exp_light(m_col, sel));
        check("step",   {23'd0, step}, {23'd0, m_step});
    endtask

    // Advance one clock, update the model, then compare 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst) model_reset();
        else      model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int steps;
        int hold;

        cyc       = 0;
        rst       = 1'b0;
        button    = 1'b0;
        enable    = 1'b0;
        auto_mode = 1'b0;
        sel       = 1'b1;
        model_reset();

        // 1. Reset values with sel=1 then sel=0
        #2;
        check("rst_colour", {21'd0, colour}, 24'h000000);
        check("rst_light_sel1", light, 24'h000000);
        check("rst_step", {23'd0, step}, 24'h000000);
        sel = 1'b0;
        #1;
        check("rst_light_sel0", light, 24'hFFFFFF);
        sel = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) tick();
        check("t1_idle_colour", {21'd0, colour}, 24'h000000);

        // 2. Manual mode, held button gives exactly one step at edge 7
        enable = 1'b1;
        tick();
        check("t2_on_colour", {21'd0, colour}, 24'h000001);
        check("t2_on_step", {23'd0, step}, 24'h000000);
        button = 1'b1;
        repeat (6) tick();
        check("t2_edge6_colour", {21'd0, colour}, 24'h000001);
        tick();
        check("t2_edge7_colour", {21'd0, colour}, 24'h000002);
        check("t2_edge7_step", {23'd0, step}, 24'h000001);
        repeat (13) tick();
        check("t2_held_colour", {21'd0, colour}, 24'h000002);
        button = 1'b0;
        repeat (8) tick();

        // 3. Short glitch ignored, a full press advances
        button = 1'b1;
        repeat (3) tick();
        button = 1'b0;
        repeat (10) tick();
        check("t3_glitch_colour", {21'd0, colour}, 24'h000002);
        button = 1'b1;
        repeat (10) tick();
        check("t3_press_colour", {21'd0, colour}, 24'h000003);
        button = 1'b0;
        repeat (8) tick();

        // Walk manually up to 111
        repeat (4) begin
            button = 1'b1;
            repeat (8) tick();
            button = 1'b0;
            repeat (8) tick();
        end
        check("t4_start_colour", {21'd0, colour}, 24'h000007);

        // 4. Auto mode: wrap 111 -> 001 after 8 cycles, then 010
        auto_mode = 1'b1;
        tick();
        check("t4_enter_colour", {21'd0, colour}, 24'h000007);
        repeat (7) tick();
        check("t4_dwell_colour", {21'd0, colour}, 24'h000007);
        tick();
        check("t4_wrap_colour", {21'd0, colour}, 24'h000001);
        check("t4_wrap_step", {23'd0, step}, 24'h000001);
        steps = 0;
        repeat (8) begin
            tick();
            steps += int'(step);
        end
        check("t4_step_count", 24'(steps), 24'd1);
        check("t4_second_colour", {21'd0, colour}, 24'h000002);

        // 5. Press event coinciding with timer expiry -> one advance
        tick();
        button = 1'b1;
        repeat (6) tick();
        check("t5_pre_colour", {21'd0, colour}, 24'h000002);
        tick();
        check("t5_merge_colour", {21'd0, colour}, 24'h000003);
        check("t5_merge_step", {23'd0, step}, 24'h000001);
        button = 1'b0;
        repeat (7) tick();
        check("t5_restart_colour", {21'd0, colour}, 24'h000003);
        tick();
        check("t5_next_colour", {21'd0, colour}, 24'h000004);

        // 6. enable=0 mid-auto, then sel=0 while sequencing
        enable = 1'b0;
        tick();
        check("t6_off_colour", {21'd0, colour}, 24'h000000);
        check("t6_off_light", light, 24'h000000);
        check("t6_off_step", {23'd0, step}, 24'h000000);
        enable = 1'b1;
        sel    = 1'b0;
        repeat (20) begin
            tick();
            check("t6_white_light", light, 24'hFFFFFF);
        end
        check("t6_seq_colour", {21'd0, colour}, 24'h000003);
        sel = 1'b1;

        // Mid-operation reset, then first enabled edge gives 001
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_mid_colour", {21'd0, colour}, 24'h000000);
        check("rst_mid_step", {23'd0, step}, 24'h000000);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rst_first_colour", {21'd0, colour}, 24'h000001);

        // Randomised soak against the model
        hold = 0;
        repeat (800) begin
            if (hold == 0) begin
                button = 1'($urandom_range(0, 1));
                hold   = int'($urandom_range(1, 12));
            end
            hold--;
            if ($urandom_range(0, 49) == 0) auto_mode = ~auto_mode;
            enable = ($urandom_range(0, 63) != 0);
            sel    = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
